// File: rtl/cpu_sram_arbiter.sv
// Two-requester arbiter for a single SRAM-like bus: data has priority, and the
// owner of each accepted request is queued so in-order responses route back.
module cpu_sram_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic SEL_INST = 1'b0;
    localparam logic SEL_DATA = 1'b1;

    logic             lock_reg, lock_next;
    logic             lock_sel_reg, lock_sel_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [DEPTH-1:0] owner_reg, owner_next;

    logic sel, full, nonempty, push, pop, head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A stalled address handshake pins the selection until it is accepted.
    assign sel      = lock_reg ? lock_sel_reg : (data_req ? SEL_DATA : SEL_INST);
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign nonempty = (count_reg != '0);
    assign bus_req  = resetn & ~full & ((sel == SEL_DATA) ? data_req : inst_req);
    assign push     = bus_req & bus_addr_ok;
    assign pop      = resetn & bus_data_ok & nonempty;
    assign head     = owner_reg[rd_ptr_reg];

    assign bus_wr    = (sel == SEL_DATA) ? data_wr    : 1'b0;
    assign bus_wstrb = (sel == SEL_DATA) ? data_wstrb : 4'h0;
    assign bus_addr  = (sel == SEL_DATA) ? data_addr  : inst_addr;
    assign bus_wdata = (sel == SEL_DATA) ? data_wdata : 32'h0;

    assign inst_addr_ok = push & (sel == SEL_INST);
    assign data_addr_ok = push & (sel == SEL_DATA);
    assign inst_data_ok = pop & (head == SEL_INST);
    assign data_data_ok = pop & (head == SEL_DATA);
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_owner
            assign owner_next[gi] = (push && wr_ptr_reg == PTR_W'(gi)) ? sel : owner_reg[gi];
        end
    endgenerate

    always_comb begin
        lock_next     = lock_reg;
        lock_sel_next = lock_sel_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        if (push) begin
            lock_next = 1'b0;
        end else if (bus_req) begin
            lock_next     = 1'b1;
            lock_sel_next = sel;
        end
        if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
        if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_reg     <= 1'b0;
            lock_sel_reg <= SEL_INST;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            owner_reg    <= '0;
        end else begin
            lock_reg     <= lock_next;
            lock_sel_reg <= lock_sel_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            owner_reg    <= owner_next;
        end
    end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Directed bench for cpu_sram_arbiter: expected response owners are queued on
// acceptance and popped when the bench drives a memory response.
module tb_cpu_sram_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;

    int tests_run    = 0;
    int tests_failed = 0;
    bit owner_q[$];   // 0 = fetch, 1 = data

    always #5 clk = ~clk;

    cpu_sram_arbiter #(.DEPTH(2)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic idle;
        inst_req = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    endtask

    // Expects an acceptance for `owner` this cycle and records it in the scoreboard.
    task automatic expect_accept(input string tag, input bit owner, input logic [31:0] addr);
        check({tag, ".bus_req"}, 32'(bus_req), 32'd1);
        check({tag, ".bus_addr"}, bus_addr, addr);
        check({tag, ".inst_addr_ok"}, 32'(inst_addr_ok), 32'(!owner));
        check({tag, ".data_addr_ok"}, 32'(data_addr_ok), 32'(owner));
        owner_q.push_back(owner);
        $display("[TB] accept %s owner=%0d addr=0x%08h", tag, owner, addr);
    endtask

    task automatic expect_stall(input string tag);
        check({tag, ".bus_req"}, 32'(bus_req), 32'd0);
        check({tag, ".inst_addr_ok"}, 32'(inst_addr_ok), 32'd0);
        check({tag, ".data_addr_ok"}, 32'(data_addr_ok), 32'd0);
        $display("[TB] stall  %s", tag);
    endtask

    // Compares routing of the response the bench is currently driving.
    task automatic check_resp(input string tag, input logic [31:0] rdata);
        bit owner;
        if (owner_q.size() == 0) begin
            check({tag, ".inst_data_ok"}, 32'(inst_data_ok), 32'd0);
            check({tag, ".data_data_ok"}, 32'(data_data_ok), 32'd0);
            $display("[TB] resp   %s ignored (nothing outstanding)", tag);
        end else begin
            owner = owner_q.pop_front();
            check({tag, ".inst_data_ok"}, 32'(inst_data_ok), 32'(!owner));
            check({tag, ".data_data_ok"}, 32'(data_data_ok), 32'(owner));
            if (owner) check({tag, ".data_rdata"}, data_rdata, rdata);
            else       check({tag, ".inst_rdata"}, inst_rdata, rdata);
            $display("[TB] resp   %s owner=%0d rdata=0x%08h", tag, owner, rdata);
        end
    endtask

    initial begin
        idle();
        resetn = 0;
        // Requests and responses during reset must be gated off.
        inst_req = 1; inst_addr = 32'h1c000000; bus_addr_ok = 1; bus_data_ok = 1;
        next_cycle(); mid();
        expect_stall("rst");
        check("rst.inst_data_ok", 32'(inst_data_ok), 32'd0);
        check("rst.data_data_ok", 32'(data_data_ok), 32'd0);
        next_cycle();
        idle(); resetn = 1;
        next_cycle();

        // 1: single fetch
        inst_req = 1; inst_addr = 32'h1c000000; bus_addr_ok = 1;
        mid();
        expect_accept("t1.fetch", 1'b0, 32'h1c000000);
        check("t1.bus_wr", 32'(bus_wr), 32'd0);
        check("t1.bus_wstrb", 32'(bus_wstrb), 32'd0);
        check("t1.bus_wdata", bus_wdata, 32'd0);
        next_cycle(); idle();
        mid(); check("t1.idle_req", 32'(bus_req), 32'd0);
        next_cycle(); bus_data_ok = 1; bus_rdata = 32'h02800c0c;
        mid(); check_resp("t1.resp", 32'h02800c0c);
        next_cycle(); idle();

        // 2: contention, data wins first
        inst_req = 1; inst_addr = 32'h1c000004;
        data_req = 1; data_addr = 32'h00001000; bus_addr_ok = 1;
        mid(); expect_accept("t2.data", 1'b1, 32'h00001000);
        next_cycle(); data_req = 0;
        mid(); expect_accept("t2.inst", 1'b0, 32'h1c000004);
        next_cycle(); inst_req = 0; bus_data_ok = 1; bus_rdata = 32'h11111111;
        mid(); check_resp("t2.resp0", 32'h11111111);
        next_cycle(); bus_rdata = 32'h22222222;
        mid(); check_resp("t2.resp1", 32'h22222222);
        next_cycle(); idle();

        // 3: lock holds fetch through a stalled handshake
        inst_req = 1; inst_addr = 32'h1c000008;
        mid(); check("t3.c0.addr", bus_addr, 32'h1c000008);
        check("t3.c0.inst_ok", 32'(inst_addr_ok), 32'd0);
        for (int c = 1; c <= 2; c++) begin
            next_cycle(); data_req = 1; data_addr = 32'h00003000;
            mid(); check($sformatf("t3.c%0d.addr", c), bus_addr, 32'h1c000008);
            check($sformatf("t3.c%0d.req", c), 32'(bus_req), 32'd1);
        end
        next_cycle(); bus_addr_ok = 1;
        mid(); expect_accept("t3.inst", 1'b0, 32'h1c000008);
        next_cycle(); inst_req = 0;
        mid(); expect_accept("t3.data", 1'b1, 32'h00003000);
        next_cycle(); data_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h33333333;
        mid(); check_resp("t3.resp0", 32'h33333333);
        next_cycle(); bus_rdata = 32'h44444444;
        mid(); check_resp("t3.resp1", 32'h44444444);
        next_cycle(); idle();

        // 4: full queue blocks further requests
        data_req = 1; data_addr = 32'h00004000; bus_addr_ok = 1;
        mid(); expect_accept("t4.ld0", 1'b1, 32'h00004000);
        next_cycle(); data_addr = 32'h00004004;
        mid(); expect_accept("t4.ld1", 1'b1, 32'h00004004);
        for (int c = 2; c <= 4; c++) begin
            next_cycle(); data_addr = 32'h00004008;
            mid(); expect_stall($sformatf("t4.full%0d", c));
        end
        next_cycle(); bus_data_ok = 1; bus_rdata = 32'h55555555;
        mid(); expect_stall("t4.pop_full"); check_resp("t4.resp0", 32'h55555555);
        next_cycle(); bus_data_ok = 0;
        mid(); expect_accept("t4.ld2", 1'b1, 32'h00004008);
        next_cycle(); data_addr = 32'h0000400c; bus_data_ok = 1; bus_rdata = 32'h66666666;
        mid(); expect_stall("t4.full7"); check_resp("t4.resp1", 32'h66666666);
        next_cycle(); bus_rdata = 32'h77777777;
        mid(); check_resp("t4.resp2", 32'h77777777); expect_accept("t4.ld3", 1'b1, 32'h0000400c);
        next_cycle(); bus_data_ok = 0; data_addr = 32'h00004010;
        mid(); expect_accept("t4.ld4", 1'b1, 32'h00004010);
        next_cycle(); data_addr = 32'h00004014;
        mid(); expect_stall("t4.full10");
        next_cycle(); data_req = 0; bus_data_ok = 1; bus_rdata = 32'h88888888;
        mid(); check_resp("t4.resp3", 32'h88888888);
        next_cycle(); bus_rdata = 32'h99999999;
        mid(); check_resp("t4.resp4", 32'h99999999);
        next_cycle(); bus_rdata = 32'haaaaaaaa;
        mid(); check_resp("t4.stray", 32'haaaaaaaa);
        next_cycle(); idle();

        // 5: store passes all fields through
        data_req = 1; data_wr = 1; data_wstrb = 4'hf; data_addr = 32'h00002000;
        data_wdata = 32'hdeadbeef; bus_addr_ok = 1;
        mid(); expect_accept("t5.st", 1'b1, 32'h00002000);
        check("t5.bus_wr", 32'(bus_wr), 32'd1);
        check("t5.bus_wstrb", 32'(bus_wstrb), 32'hf);
        check("t5.bus_wdata", bus_wdata, 32'hdeadbeef);
        next_cycle(); idle();
        next_cycle(); bus_data_ok = 1;
        mid(); check_resp("t5.resp", 32'h0);
        next_cycle(); idle();

        // 6: reset discards an outstanding request
        inst_req = 1; inst_addr = 32'h1c00000c; bus_addr_ok = 1;
        mid(); expect_accept("t6.fetch", 1'b0, 32'h1c00000c);
        next_cycle(); resetn = 0; data_req = 1; data_addr = 32'h00005000;
        bus_data_ok = 1; bus_rdata = 32'hbbbbbbbb;
        mid(); expect_stall("t6.rst");
        check("t6.rst.inst_data_ok", 32'(inst_data_ok), 32'd0);
        check("t6.rst.data_data_ok", 32'(data_data_ok), 32'd0);
        owner_q.delete();
        next_cycle(); resetn = 1; idle(); bus_data_ok = 1; bus_rdata = 32'hcccccccc;
        mid(); check_resp("t6.stale", 32'hcccccccc);
        next_cycle(); idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
